scan_guard_mc: RTL and testbench
================================

Name: scan_guard_mc

Overview:
- Multi-chain scan-access protection unit for the MCSE security engine. Generalises single-chain gating to NUM_CHAINS chains and NUM_KEYS stored unlock keys.
- Each key unlocks a programmable subset of chains. Failed attempts are counted, and a sticky lockout engages after MAX_ATTEMPTS failures.
- Sits between the design's scan chain outputs and the chip scan pins. Golden keys and chain masks come from the control unit.

Parameters:
NUM_CHAINS, 4, number of independent scan chains guarded
KEY_WIDTH, 64, width of one unlock key in bits
NUM_KEYS, 4, number of golden keys held by control unit
MAX_ATTEMPTS, 3, consecutive failed compares before lockout (1..15)
LFSR_WIDTH, 16, width of garbage LFSR (used only with optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
scan_enable  in  1  scan shift enable; scan outputs update only when high
scan_in  in  NUM_CHAINS  raw scan chain outputs from design
key_in  in  KEY_WIDTH  candidate key from tester
key_sel  in  $clog2(NUM_KEYS)  index of golden key to compare against
key_valid  in  1  one-cycle strobe: key_in/key_sel valid
relock  in  1  drop all unlocks, return to LOCKED
golden_keys  in  NUM_KEYS*KEY_WIDTH  flattened golden keys, key k at [k*KEY_WIDTH +: KEY_WIDTH]
key_chain_mask  in  NUM_KEYS*NUM_CHAINS  chains unlocked by key k at [k*NUM_CHAINS +: NUM_CHAINS]
scan_out  out  NUM_CHAINS  protected scan outputs
chain_unlock  out  NUM_CHAINS  per-chain unlock status
scan_unlock  out  1  OR of chain_unlock
key_ack  out  1  one-cycle pulse on successful compare
key_fail  out  1  one-cycle pulse on failed compare
lockout  out  1  sticky lockout flag
attempts_left  out  4  remaining attempts before lockout

Behaviour:
- Reset (rst_n low at posedge clk):
  - State LOCKED.
  - scan_out=0, chain_unlock=0, scan_unlock=0, key_ack=0, key_fail=0, lockout=0.
  - attempts_left=MAX_ATTEMPTS.
  - Reset mid-compare aborts the compare with no ack/fail pulse.
- State LOCKED:
  - key_valid=1 registers key_in and key_sel, then moves to CHECK.
  - key_sel >= NUM_KEYS counts as a failed attempt.
- State CHECK (one cycle): compare registered key against golden_keys[key_sel].
  - Match: chain_unlock <= key_chain_mask[key_sel], attempts_left <= MAX_ATTEMPTS, key_ack=1, go to UNLOCKED.
  - Mismatch: attempts_left decrements and key_fail=1. If the new value is 0, set lockout=1 and go to LOCKOUT; otherwise return to LOCKED.
- Latency: key_valid at cycle t gives ack/fail registered and visible at cycle t+2. chain_unlock is valid the same cycle as key_ack.
- State UNLOCKED:
  - key_valid: new compare through CHECK. On success the masks OR together (cumulative unlock). On failure the existing unlocks are kept and attempts are decremented.
  - relock=1: chain_unlock <= 0, go to LOCKED; attempts_left unchanged.
- State LOCKOUT:
  - Absorbing; exited only by rst_n.
  - key_valid and relock are ignored, no ack/fail pulses, chain_unlock forced 0.
- key_valid during CHECK is ignored (no queueing).
- relock and key_valid in the same cycle: relock wins and the key is dropped.
- Scan path, registered, one cycle latency:
  - scan_enable=0: scan_out holds its value.
  - scan_enable=1, chain i unlocked: scan_out[i] <= scan_in[i].
  - scan_enable=1, chain i locked: scan_out[i] <= garbage bit (0 unless the optional feature is enabled).
- Unlock and relock take effect on the scan path the cycle after chain_unlock changes.
- The key compare uses full-width equality, evaluated only in CHECK. Golden keys are never routed to any output.

Optional Feature:
- Macro SCAN_GUARD_LFSR_EN.
- Defined:
  - A Fibonacci LFSR of width LFSR_WIDTH, seeded at reset to the nonzero constant 16'hACE1 (truncated or zero-extended), advances every cycle scan_enable=1.
  - Locked chain i outputs lfsr[i % LFSR_WIDTH] instead of 0.
  - In LOCKOUT all chains output LFSR bits.
- Undefined: locked chains output constant 0; no LFSR logic is instantiated.

Decomposition:
- Package scan_guard_pkg:
  - state enum typedef (LOCKED, CHECK, UNLOCKED, LOCKOUT).
  - LFSR seed constant and tap constants.
- Sub-module scan_guard_lfsr: parametrised LFSR with enable, instantiated only under SCAN_GUARD_LFSR_EN.
- FSM, attempt counter and scan gating live in the top.

Test Plan:
- Reset, then scan_enable=1, scan_in=4'b1111, no key -> scan_out=4'b0000, scan_unlock=0, attempts_left=3.
- golden key 0 = 64'hDEADBEEF_CAFEF00D, mask0=4'b0101; present the matching key with key_sel=0 -> key_ack at t+2, chain_unlock=4'b0101, next scan_out=4'b0101 for scan_in=4'b1111.
- Three wrong keys in LOCKED -> key_fail pulses, attempts_left 2,1,0, lockout=1. A subsequent correct key gives no ack and chain_unlock stays 0 until rst_n.
- UNLOCKED with key0, then key1 correct (mask1=4'b1000) -> chain_unlock=4'b1101. Then relock and key_valid in the same cycle -> chain_unlock=0, no ack.
- Two fails then one success -> attempts_left returns to 3. key_sel=3 with NUM_KEYS=3 -> key_fail.
- With SCAN_GUARD_LFSR_EN, locked and scan_enable=1 for 20 cycles -> scan_out follows the reference LFSR model from seed ACE1, never constant. With scan_enable=0 the LFSR and scan_out hold.

Source files
------------

// File: rtl/scan_guard_pkg.sv
// scan_guard_pkg: shared types and constants for the multi-chain scan guard.
//   state_e      : FSM states (LOCKED, CHECK, UNLOCKED, LOCKOUT)
//   LFSR_SEED    : reset value of the garbage LFSR (truncated/zero-extended to width)
//   lfsr_taps()  : Fibonacci feedback tap mask for a given LFSR width
// Optional feature macro: SCAN_GUARD_LFSR_EN (consumed by scan_guard_mc).
package scan_guard_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    CHECK    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 : feedback from bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  // Tap mask: bit j set means lfsr[j] feeds the XOR. Widths outside the table
  // fall back to x^w + x^(w-1) + 1, which is not guaranteed maximal length.
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return {48'h0, LFSR_TAPS_16};
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h3 << (w - 2);
    endcase
  endfunction

endpackage

// File: rtl/scan_guard_lfsr.sv
// scan_guard_lfsr: Fibonacci LFSR producing garbage bits for locked chains.
//   clk, rst_n : clock, synchronous active-low reset (loads SEED)
//   en         : advance one step this cycle
//   lfsr       : current register value
// Shifts left; the XOR of the tapped bits enters at bit 0.
module scan_guard_lfsr #(
  parameter int                 WIDTH = 16,
  parameter logic [WIDTH-1:0]   SEED  = '1,
  parameter logic [WIDTH-1:0]   TAPS  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] lfsr
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/scan_guard_mc.sv
// scan_guard_mc: multi-chain scan access protection.
//   Inputs : clk, rst_n (sync, active low), scan_enable, scan_in[NUM_CHAINS],
//            key_in/key_sel/key_valid (unlock attempt), relock,
//            golden_keys (key k at [k*KEY_WIDTH +: KEY_WIDTH]),
//            key_chain_mask (chains for key k at [k*NUM_CHAINS +: NUM_CHAINS])
//   Outputs: scan_out, chain_unlock, scan_unlock, key_ack/key_fail (1-cycle
//            pulses), lockout (sticky), attempts_left
// An attempt is captured in LOCKED/UNLOCKED, compared during the single CHECK
// cycle, and the result registered, so ack/fail appear two cycles after
// key_valid. Unlocks accumulate across successful keys until relock.
// Optional feature macro SCAN_GUARD_LFSR_EN: locked chains emit LFSR bits
// instead of constant 0.
module scan_guard_mc
  import scan_guard_pkg::*;
#(
  parameter int NUM_CHAINS   = 4,
  parameter int KEY_WIDTH    = 64,
  parameter int NUM_KEYS     = 4,
  parameter int MAX_ATTEMPTS = 3,
  parameter int LFSR_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            scan_enable,
  input  logic [NUM_CHAINS-1:0]           scan_in,
  input  logic [KEY_WIDTH-1:0]            key_in,
  input  logic [$clog2(NUM_KEYS)-1:0]     key_sel,
  input  logic                            key_valid,
  input  logic                            relock,
  input  logic [NUM_KEYS*KEY_WIDTH-1:0]   golden_keys,
  input  logic [NUM_KEYS*NUM_CHAINS-1:0]  key_chain_mask,
  output logic [NUM_CHAINS-1:0]           scan_out,
  output logic [NUM_CHAINS-1:0]           chain_unlock,
  output logic                            scan_unlock,
  output logic                            key_ack,
  output logic                            key_fail,
  output logic                            lockout,
  output logic [3:0]                      attempts_left
);

  localparam int         KSW      = $clog2(NUM_KEYS);
  localparam logic [3:0] ATT_INIT = 4'(MAX_ATTEMPTS);

  state_e                state_q, state_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic [KSW-1:0]        sel_q, sel_d;
  logic                  from_unl_q, from_unl_d;   // attempt began in UNLOCKED
  logic [NUM_CHAINS-1:0] chain_unlock_q, chain_unlock_d;
  logic [NUM_CHAINS-1:0] scan_out_q, scan_out_d;
  logic                  key_ack_q, key_ack_d;
  logic                  key_fail_q, key_fail_d;
  logic                  lockout_q, lockout_d;
  logic [3:0]            attempts_q, attempts_d;

  logic                  sel_ok, key_match;
  logic [KEY_WIDTH-1:0]  golden_sel;
  logic [NUM_CHAINS-1:0] mask_sel;
  logic [NUM_CHAINS-1:0] garbage;

  // Select golden key / mask by a compare loop so an out-of-range key_sel
  // never produces an out-of-bounds part-select; sel_ok then forces a miss.
  always_comb begin
    golden_sel = '0;
    mask_sel   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (int'(sel_q) == k) begin
        golden_sel = golden_keys[k*KEY_WIDTH +: KEY_WIDTH];
        mask_sel   = key_chain_mask[k*NUM_CHAINS +: NUM_CHAINS];
      end
    end
    sel_ok    = int'(sel_q) < NUM_KEYS;
    key_match = sel_ok && (key_q == golden_sel);
  end

`ifdef SCAN_GUARD_LFSR_EN
  localparam logic [LFSR_WIDTH-1:0] SEED = LFSR_WIDTH'(LFSR_SEED);
  localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(lfsr_taps(LFSR_WIDTH));

  logic [LFSR_WIDTH-1:0] lfsr;

  scan_guard_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (scan_enable),
    .lfsr  (lfsr)
  );

  always_comb begin
    garbage = '0;
    for (int i = 0; i < NUM_CHAINS; i++) garbage[i] = lfsr[i % LFSR_WIDTH];
  end
`else
  assign garbage = '0;
`endif

  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    sel_d          = sel_q;
    from_unl_d     = from_unl_q;
    chain_unlock_d = chain_unlock_q;
    attempts_d     = attempts_q;
    lockout_d      = lockout_q;
    key_ack_d      = 1'b0;
    key_fail_d     = 1'b0;

    case (state_q)
      LOCKED: begin
        // relock here has nothing to drop but still swallows a same-cycle key
        if (!relock && key_valid) begin
          key_d      = key_in;
          sel_d      = key_sel;
          from_unl_d = 1'b0;
          state_d    = CHECK;
        end
      end
      UNLOCKED: begin
        if (relock) begin
          chain_unlock_d = '0;
          state_d        = LOCKED;
        end else if (key_valid) begin
          key_d      = key_in;
          sel_d      = key_sel;
          from_unl_d = 1'b1;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        // key_valid and relock are deliberately not looked at here
        if (key_match) begin
          chain_unlock_d = chain_unlock_q | mask_sel;
          attempts_d     = ATT_INIT;
          key_ack_d      = 1'b1;
          state_d        = UNLOCKED;
        end else begin
          attempts_d = attempts_q - 4'd1;
          key_fail_d = 1'b1;
          if (attempts_d == 4'd0) begin
            lockout_d      = 1'b1;
            chain_unlock_d = '0;
            state_d        = LOCKOUT;
          end else begin
            state_d = from_unl_q ? UNLOCKED : LOCKED;
          end
        end
      end
      LOCKOUT: chain_unlock_d = '0;
      default: state_d = LOCKED;
    endcase
  end

  // Gating uses the registered unlock, so an unlock change reaches scan_out
  // one cycle after it appears on chain_unlock.
  always_comb begin
    scan_out_d = scan_out_q;
    if (scan_enable) scan_out_d = (scan_in & chain_unlock_q) | (garbage & ~chain_unlock_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= LOCKED;
      key_q          <= '0;
      sel_q          <= '0;
      from_unl_q     <= 1'b0;
      chain_unlock_q <= '0;
      scan_out_q     <= '0;
      key_ack_q      <= 1'b0;
      key_fail_q     <= 1'b0;
      lockout_q      <= 1'b0;
      attempts_q     <= ATT_INIT;
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      sel_q          <= sel_d;
      from_unl_q     <= from_unl_d;
      chain_unlock_q <= chain_unlock_d;
      scan_out_q     <= scan_out_d;
      key_ack_q      <= key_ack_d;
      key_fail_q     <= key_fail_d;
      lockout_q      <= lockout_d;
      attempts_q     <= attempts_d;
    end
  end

  assign scan_out      = scan_out_q;
  assign chain_unlock  = chain_unlock_q;
  assign scan_unlock   = |chain_unlock_q;
  assign key_ack       = key_ack_q;
  assign key_fail      = key_fail_q;
  assign lockout       = lockout_q;
  assign attempts_left = attempts_q;

endmodule

// File: tb/tb_scan_guard_mc.sv
// tb_scan_guard_mc: directed table of cycle vectors for the scan guard
// (NUM_KEYS=3 so key_sel=3 is out of range), followed by randomized traffic
// checked against a pending-attempt reference model. Honours SCAN_GUARD_LFSR_EN.
module tb_scan_guard_mc;

  localparam int NC = 4, KW = 64, NK = 3, MA = 3, LW = 16;

  logic          clk = 1'b0, rst_n = 1'b0, scan_enable = 1'b0;
  logic [NC-1:0] scan_in = '0;
  logic [KW-1:0] key_in = '0;
  logic [1:0]    key_sel = '0;
  logic          key_valid = 1'b0, relock = 1'b0;
  logic [NK*KW-1:0] golden_keys;
  logic [NK*NC-1:0] key_chain_mask;
  logic [NC-1:0] scan_out, chain_unlock;
  logic          scan_unlock, key_ack, key_fail, lockout;
  logic [3:0]    attempts_left;

  scan_guard_mc #(.NUM_CHAINS(NC), .KEY_WIDTH(KW), .NUM_KEYS(NK),
                  .MAX_ATTEMPTS(MA), .LFSR_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .scan_enable(scan_enable), .scan_in(scan_in),
    .key_in(key_in), .key_sel(key_sel), .key_valid(key_valid), .relock(relock),
    .golden_keys(golden_keys), .key_chain_mask(key_chain_mask),
    .scan_out(scan_out), .chain_unlock(chain_unlock), .scan_unlock(scan_unlock),
    .key_ack(key_ack), .key_fail(key_fail), .lockout(lockout),
    .attempts_left(attempts_left));

  always #5 clk = ~clk;

  logic [KW-1:0] gk [NK];
  logic [NC-1:0] gm [NK];
  initial begin
    gk[0] = 64'hDEADBEEF_CAFEF00D; gm[0] = 4'b0101;
    gk[1] = 64'h01234567_89ABCDEF; gm[1] = 4'b1000;
    gk[2] = 64'hFEDCBA98_76543210; gm[2] = 4'b0010;
  end
  assign golden_keys    = {gk[2], gk[1], gk[0]};
  assign key_chain_mask = {gm[2], gm[1], gm[0]};

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Out-of-range selects are handed key 0's golden value: it must still fail.
  function automatic logic [KW-1:0] pick_key(input logic [1:0] sel, input bit good);
    logic [KW-1:0] k;
    k = (int'(sel) < NK) ? gk[sel] : gk[0];
    if (!good) k = k ^ {$urandom, ($urandom | 32'h1)};
    return k;
  endfunction

  typedef struct {
    bit rst, se; logic [3:0] si; bit kv; logic [1:0] sel; bit good, rl;
    logic [3:0] cu, so; bit ack, fail, lk; logic [3:0] att;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit rst, se, input logic [3:0] si, input bit kv,
                     input logic [1:0] sel, input bit good, rl,
                     input logic [3:0] cu, so, input bit ack, fail, lk,
                     input logic [3:0] att);
    vec_t v;
    v = '{rst, se, si, kv, sel, good, rl, cu, so, ack, fail, lk, att};
    vq.push_back(v);
  endtask

  // Reference model: an attempt is held pending for one cycle, then resolved.
  logic [3:0]    m_cu, m_so, m_att;
  bit            m_ack, m_fail, m_lock, m_pend;
  logic [KW-1:0] m_pkey;
  logic [1:0]    m_psel;
  logic [15:0]   m_lfsr;

  task automatic model_step();
    logic [3:0] g;
    bit hit;
    if (!rst_n) begin
      m_cu = 0; m_so = 0; m_att = MA; m_ack = 0; m_fail = 0; m_lock = 0;
      m_pend = 0; m_lfsr = 16'hACE1;
      return;
    end
`ifdef SCAN_GUARD_LFSR_EN
    g = m_lfsr[3:0];
`else
    g = 4'b0;
`endif
    if (scan_enable) begin
      m_so   = (scan_in & m_cu) | (g & ~m_cu);
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    m_ack = 0; m_fail = 0;
    if (m_pend) begin
      m_pend = 0;
      hit = (int'(m_psel) < NK) && (m_pkey == gk[m_psel]);
      if (hit) begin
        m_cu = m_cu | gm[m_psel]; m_att = MA; m_ack = 1;
      end else begin
        m_att = m_att - 1; m_fail = 1;
        if (m_att == 0) begin m_lock = 1; m_cu = 0; end
      end
    end else if (m_lock) begin
    end else if (relock) begin
      m_cu = 0;
    end else if (key_valid) begin
      m_pend = 1; m_pkey = key_in; m_psel = key_sel;
    end
  endtask

  task automatic step_check(input string nm);
    model_step();
    @(posedge clk); #1;
    chk(nm, {16'h0, chain_unlock, scan_out, scan_unlock, key_ack, key_fail, lockout, attempts_left},
            {16'h0, m_cu, m_so, |m_cu, m_ack, m_fail, m_lock, m_att});
  endtask

  initial begin
    // rst se  si  kv sel good rl | cu  so  ack fail lk att
    add(0,1,4'hF,0,0,0,0, 4'h0,4'h0,0,0,0,3);  // reset
    add(1,1,4'hF,0,0,0,0, 4'h0,4'h0,0,0,0,3);  // locked, scan blocked
    add(1,1,4'hF,1,0,1,0, 4'h0,4'h0,0,0,0,3);  // key0 good
    add(1,1,4'hF,0,0,0,0, 4'h5,4'h0,1,0,0,3);  // ack at t+2
    add(1,1,4'hF,0,0,0,0, 4'h5,4'h5,0,0,0,3);  // scan follows next cycle
    add(1,1,4'hF,1,1,1,0, 4'h5,4'h5,0,0,0,3);  // key1 good from UNLOCKED
    add(1,1,4'hF,0,0,0,0, 4'hD,4'h5,1,0,0,3);  // cumulative unlock
    add(1,1,4'hF,0,0,0,0, 4'hD,4'hD,0,0,0,3);
    add(1,0,4'h0,0,0,0,0, 4'hD,4'hD,0,0,0,3);  // scan_enable=0 holds
    add(1,1,4'hA,0,0,0,0, 4'hD,4'h8,0,0,0,3);
    add(1,1,4'hF,1,0,1,1, 4'h0,4'hD,0,0,0,3);  // relock + key same cycle
    add(1,1,4'hF,0,0,0,0, 4'h0,4'h0,0,0,0,3);
    add(1,1,4'hF,0,0,0,0, 4'h0,4'h0,0,0,0,3);  // dropped key gives no ack
    add(1,1,4'hF,1,0,0,0, 4'h0,4'h0,0,0,0,3);  // wrong key
    add(1,1,4'hF,0,0,0,0, 4'h0,4'h0,0,1,0,2);
    add(1,1,4'hF,1,3,1,0, 4'h0,4'h0,0,0,0,2);  // key_sel out of range
    add(1,1,4'hF,0,0,0,0, 4'h0,4'h0,0,1,0,1);
    add(1,1,4'hF,1,2,1,0, 4'h0,4'h0,0,0,0,1);  // success restores attempts
    add(1,1,4'hF,0,0,0,0, 4'h2,4'h0,1,0,0,3);
    add(1,1,4'hF,1,1,0,0, 4'h2,4'h2,0,0,0,3);  // fail while UNLOCKED
    add(1,1,4'hF,0,0,0,0, 4'h2,4'h2,0,1,0,2);  // unlocks kept
    add(1,1,4'hF,1,0,0,0, 4'h2,4'h2,0,0,0,2);
    add(1,1,4'hF,1,0,0,0, 4'h2,4'h2,0,1,0,1);  // key during CHECK ignored
    add(1,1,4'hF,0,0,0,0, 4'h2,4'h2,0,0,0,1);
    add(1,1,4'hF,1,0,0,0, 4'h2,4'h2,0,0,0,1);
    add(1,1,4'hF,0,0,0,0, 4'h0,4'h2,0,1,1,0);  // lockout
    add(1,1,4'hF,1,0,1,0, 4'h0,4'h0,0,0,1,0);  // good key ignored
    add(1,1,4'hF,0,0,0,0, 4'h0,4'h0,0,0,1,0);
    add(1,1,4'hF,0,0,0,1, 4'h0,4'h0,0,0,1,0);  // relock ignored
    add(0,1,4'hF,0,0,0,0, 4'h0,4'h0,0,0,0,3);  // reset clears lockout
    add(1,1,4'hF,1,0,1,0, 4'h0,4'h0,0,0,0,3);
    add(0,1,4'hF,0,0,0,0, 4'h0,4'h0,0,0,0,3);  // reset mid-compare
    add(1,1,4'hF,0,0,0,0, 4'h0,4'h0,0,0,0,3);  // no ack after abort

    foreach (vq[i]) begin
      rst_n = vq[i].rst; scan_enable = vq[i].se; scan_in = vq[i].si;
      key_valid = vq[i].kv; key_sel = vq[i].sel; relock = vq[i].rl;
      key_in = pick_key(vq[i].sel, vq[i].good);
      @(posedge clk); #1;
      chk($sformatf("v%0d.chain_unlock", i), 32'(chain_unlock), 32'(vq[i].cu));
`ifndef SCAN_GUARD_LFSR_EN
      chk($sformatf("v%0d.scan_out", i), 32'(scan_out), 32'(vq[i].so));
`endif
      chk($sformatf("v%0d.scan_unlock", i), 32'(scan_unlock), 32'(|vq[i].cu));
      chk($sformatf("v%0d.key_ack", i), 32'(key_ack), 32'(vq[i].ack));
      chk($sformatf("v%0d.key_fail", i), 32'(key_fail), 32'(vq[i].fail));
      chk($sformatf("v%0d.lockout", i), 32'(lockout), 32'(vq[i].lk));
      chk($sformatf("v%0d.attempts_left", i), 32'(attempts_left), 32'(vq[i].att));
    end

    // Randomized traffic; first cycle is a reset to align the model.
    for (int c = 0; c < 800; c++) begin
      logic [1:0] s;
      rst_n       = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      scan_enable = $urandom_range(0, 9) < 7;
      scan_in     = 4'($urandom);
      key_valid   = $urandom_range(0, 9) < 3;
      s           = 2'($urandom_range(0, 3));
      key_sel     = s;
      key_in      = pick_key(s, $urandom_range(0, 1) == 1);
      relock      = $urandom_range(0, 14) == 0;
      step_check($sformatf("rand%0d", c));
    end

`ifdef SCAN_GUARD_LFSR_EN
    begin
      logic [3:0] first;
      bit varied;
      key_valid = 0; relock = 0; scan_in = 4'hF;
      rst_n = 0; step_check("lfsr_rst");
      rst_n = 1; scan_enable = 1; varied = 0;
      for (int c = 0; c < 20; c++) begin
        step_check($sformatf("lfsr_run%0d", c));
        if (c == 0) first = scan_out;
        else if (scan_out != first) varied = 1;
      end
      chk("lfsr_varies", 32'(varied), 32'd1);
      scan_enable = 0;
      for (int c = 0; c < 5; c++) step_check($sformatf("lfsr_hold%0d", c));
      scan_enable = 1;
      for (int c = 0; c < 3; c++) step_check($sformatf("lfsr_resume%0d", c));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
